// File: rtl/button_pkg.sv
// Shared types and constants for the button front-end: FSM states, command
// encoding, counter width and the fixed-priority arbitration helper.
package button_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_INC  = 2'd1,
    CMD_DEC  = 2'd2,
    CMD_CLR  = 2'd3
  } cmd_t;

  // Clear beats decrement beats increment when several levels are high together.
  function automatic cmd_t pick_cmd(input logic inc, input logic dec, input logic clr);
    if (clr) begin
      return CMD_CLR;
    end else if (dec) begin
      return CMD_DEC;
    end else if (inc) begin
      return CMD_INC;
    end
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/button_counter_arbiter_if.sv
// Board-side bundle: three active-low button pins in, LED counter and status out.
interface button_counter_arbiter_if;

  logic       inc_btn;
  logic       dec_btn;
  logic       clr_btn;
  logic [3:0] led;
  logic       busy;
  logic [1:0] cmd;

  modport master (
    output inc_btn,
    output dec_btn,
    output clr_btn,
    input  led,
    input  busy,
    input  cmd
  );

  modport slave (
    input  inc_btn,
    input  dec_btn,
    input  clr_btn,
    output led,
    output busy,
    output cmd
  );

endinterface

// File: rtl/btn_debounce.sv
// Synchronizes one active-low push-button and produces an active-high level
// that only flips after the input has disagreed for DEBOUNCE_COUNT cycles.
module btn_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_COUNT = 32'd5000000
) (
  input  logic clk,
  input  logic rst_btn,
  input  logic btn_n,
  output logic level
);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter tops out at DEBOUNCE_COUNT and clears on the flip, so it never wraps.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if ((~sync2_q) != level_q) begin
      if (cnt_q == DEBOUNCE_COUNT) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/button_counter_arbiter.sv
// LED counter front-end: debounces three buttons, arbitrates them by priority
// and applies one counter update per press, with auto-repeat while held.
module button_counter_arbiter
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_COUNT = 32'd5000000,
  parameter int unsigned REPEAT_DELAY   = 32'd25000000,
  parameter int unsigned REPEAT_RATE    = 32'd5000000
) (
  input  logic                     clk,
  input  logic                     rst_btn,
  button_counter_arbiter_if.slave  bus
);

  logic inc_lvl;
  logic dec_lvl;
  logic clr_lvl;
  logic held;

  state_t           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [3:0]       led_q, led_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             rpt_q, rpt_d;
  logic             busy_q, busy_d;

  btn_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_inc (
    .clk     (clk),
    .rst_btn (rst_btn),
    .btn_n   (bus.inc_btn),
    .level   (inc_lvl)
  );

  btn_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_dec (
    .clk     (clk),
    .rst_btn (rst_btn),
    .btn_n   (bus.dec_btn),
    .level   (dec_lvl)
  );

  btn_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_clr (
    .clk     (clk),
    .rst_btn (rst_btn),
    .btn_n   (bus.clr_btn),
    .level   (clr_lvl)
  );

  // Only the button that won arbitration can end or extend the current press.
  always_comb begin
    held = 1'b0;
    case (cmd_q)
      CMD_INC: held = inc_lvl;
      CMD_DEC: held = dec_lvl;
      CMD_CLR: held = clr_lvl;
      default: held = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    led_d   = led_q;
    hold_d  = hold_q;
    rpt_d   = rpt_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (inc_lvl || dec_lvl || clr_lvl) begin
          cmd_d   = pick_cmd(inc_lvl, dec_lvl, clr_lvl);
          rpt_d   = 1'b0;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        case (cmd_q)
          CMD_INC: led_d = led_q + 4'd1;
          CMD_DEC: led_d = led_q - 4'd1;
          CMD_CLR: led_d = 4'd0;
          default: led_d = led_q;
        endcase
        hold_d  = rpt_q ? CNT_W'(REPEAT_RATE) : CNT_W'(REPEAT_DELAY);
        rpt_d   = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // Release wins over repeat; clear just waits out the hold at zero.
        if (!held) begin
          cmd_d   = CMD_NONE;
          state_d = ST_IDLE;
        end else if ((hold_q == '0) && (cmd_q != CMD_CLR)) begin
          state_d = ST_APPLY;
        end else if (hold_q != '0) begin
          hold_d = hold_q - CNT_W'(1);
        end
      end
      default: begin
        cmd_d   = CMD_NONE;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_NONE;
      led_q   <= 4'd0;
      hold_q  <= '0;
      rpt_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      led_q   <= led_d;
      hold_q  <= hold_d;
      rpt_q   <= rpt_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.busy = busy_q;
  assign bus.cmd  = cmd_q;

endmodule

// File: tb/tb_button_counter_arbiter.sv
// Directed bench for button_counter_arbiter with short debounce/repeat timings;
// vectors carry hand-computed LED, busy and command values.
module tb_button_counter_arbiter;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RR = 3;

  logic clk = 1'b0;
  logic rst_btn;

  button_counter_arbiter_if bus ();

  button_counter_arbiter #(
    .DEBOUNCE_COUNT (DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk     (clk),
    .rst_btn (rst_btn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       inc;
    logic       dec;
    logic       clr;
    int         ticks;
    logic [3:0] led;
    logic       busy;
    logic [1:0] cmd;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int testsRun    = 0;
  int testsFailed = 0;

  task automatic addVec(input logic rst, input logic inc, input logic dec, input logic clr,
                        input int ticks, input logic [3:0] led, input logic busy,
                        input logic [1:0] cmd, input string name);
    vec_t v;
    v.rst = rst; v.inc = inc; v.dec = dec; v.clr = clr; v.ticks = ticks;
    v.led = led; v.busy = busy; v.cmd = cmd; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Inputs change 1 time unit after a rising edge; the next edge is the first to sample them.
  task automatic applyStimulus(input logic rst, input logic inc, input logic dec,
                               input logic clr, input int ticks);
    rst_btn     = rst;
    bus.inc_btn = inc;
    bus.dec_btn = dec;
    bus.clr_btn = clr;
    tick(ticks);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] led,
                             input logic busy, input logic [1:0] cmd);
    testsRun++;
    if (bus.led !== led) begin
      testsFailed++;
      $display("[TB] FAIL %s led: got %0d, want %0d", name, bus.led, led);
    end
    testsRun++;
    if (bus.busy !== busy) begin
      testsFailed++;
      $display("[TB] FAIL %s busy: got %0b, want %0b", name, bus.busy, busy);
    end
    testsRun++;
    if (bus.cmd !== cmd) begin
      testsFailed++;
      $display("[TB] FAIL %s cmd: got %0d, want %0d", name, bus.cmd, cmd);
    end
  endtask

  initial begin
    int n;
    logic [3:0] startLed;

    rst_btn     = 1'b0;
    bus.inc_btn = 1'b1;
    bus.dec_btn = 1'b1;
    bus.clr_btn = 1'b1;

    //     rst inc dec clr ticks led busy cmd
    addVec(0, 1, 1, 1,  3,  0, 0, 0, "reset");
    addVec(1, 1, 1, 1,  2,  0, 0, 0, "idle");
    addVec(1, 0, 1, 1,  3,  0, 0, 0, "glitch_low");
    addVec(1, 1, 1, 1, 10,  0, 0, 0, "glitch_ignored");
    addVec(1, 0, 1, 1,  8,  0, 1, 1, "press_apply");
    addVec(1, 0, 1, 1,  1,  1, 1, 1, "press_led1");
    addVec(1, 0, 1, 1,  3,  1, 1, 1, "press_hold");
    addVec(1, 1, 1, 1,  7,  1, 1, 1, "release_hold");
    addVec(1, 1, 1, 1,  1,  1, 0, 0, "release_idle");
    addVec(1, 1, 1, 1,  5,  1, 0, 0, "no_extra");
    addVec(1, 0, 1, 1,  9,  2, 1, 1, "rpt_first");
    addVec(1, 0, 1, 1, 11,  2, 1, 1, "rpt_delay");
    addVec(1, 0, 1, 1,  1,  3, 1, 1, "rpt_2");
    addVec(1, 0, 1, 1,  4,  3, 1, 1, "rpt_rate");
    addVec(1, 0, 1, 1,  1,  4, 1, 1, "rpt_3");
    addVec(1, 0, 1, 1,  5,  5, 1, 1, "rpt_4");
    addVec(1, 1, 1, 1,  5,  6, 1, 1, "rpt_in_release");
    addVec(1, 1, 1, 1,  3,  6, 0, 0, "rpt_released");
    addVec(0, 1, 1, 1,  2,  0, 0, 0, "reset_again");
    addVec(1, 1, 1, 1,  1,  0, 0, 0, "reset_release");
    addVec(1, 1, 0, 1,  9, 15, 1, 2, "dec_wrap");
    addVec(1, 1, 1, 1,  8, 15, 0, 0, "dec_release");
    addVec(1, 0, 1, 1,  9,  0, 1, 1, "inc_wrap");
    addVec(1, 1, 1, 1,  8,  0, 0, 0, "inc_release");
    addVec(1, 0, 1, 1, 31,  4, 1, 1, "build_4");
    addVec(1, 1, 1, 1,  5,  5, 1, 1, "build_5");
    addVec(1, 1, 1, 1,  3,  5, 0, 0, "build_idle");
    addVec(1, 0, 1, 0,  8,  5, 1, 3, "clr_inc_apply");
    addVec(1, 0, 1, 0,  1,  0, 1, 3, "clr_led0");
    addVec(1, 0, 1, 0, 20,  0, 1, 3, "clr_no_repeat");
    addVec(1, 0, 1, 1,  7,  0, 1, 3, "clr_release_hold");
    addVec(1, 0, 1, 1,  2,  0, 1, 1, "inc_rearb");
    addVec(1, 0, 1, 1,  1,  1, 1, 1, "inc_after_clr");
    addVec(1, 0, 1, 1, 12,  2, 1, 1, "rpt_after_clr");
    addVec(1, 0, 1, 1,  5,  3, 1, 1, "midrpt_led3");
    addVec(0, 0, 1, 1,  1,  0, 0, 0, "rst_midrpt");
    addVec(0, 0, 1, 1, 15,  0, 0, 0, "rst_held");
    addVec(1, 0, 1, 1,  8,  0, 1, 1, "redebounce_apply");
    addVec(1, 0, 1, 1,  1,  1, 1, 1, "redebounce_led1");
    addVec(1, 1, 1, 1,  8,  1, 0, 0, "final_release");

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].inc, vecs[i].dec, vecs[i].clr, vecs[i].ticks);
      checkOutput(vecs[i].name, vecs[i].led, vecs[i].busy, vecs[i].cmd);
    end

    // A pulse of exactly DB pin cycles falls one short of being accepted.
    applyStimulus(1, 0, 1, 1, DB);
    applyStimulus(1, 1, 1, 1, 12);
    checkOutput("pulse_db_cycles", 1, 0, 0);

    // One cycle longer is accepted and produces a single update.
    applyStimulus(1, 0, 1, 1, DB + 1);
    applyStimulus(1, 1, 1, 1, 15);
    checkOutput("pulse_db_plus1", 2, 0, 0);

    // Press latency: led should first change after edge 8, i.e. on the 9th tick.
    startLed    = bus.led;
    bus.dec_btn = 1'b0;
    n = 0;
    while ((bus.led === startLed) && (n < 40)) begin
      tick(1);
      n++;
    end
    testsRun++;
    if (n != 9) begin
      testsFailed++;
      $display("[TB] FAIL dec_latency ticks: got %0d, want %0d", n, 9);
    end
    checkOutput("dec_latency_val", 1, 1, 2);
    applyStimulus(1, 1, 1, 1, 10);
    checkOutput("dec_latency_rel", 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/button_counter_arbiter.md
# button_counter_arbiter

Front-end controller for the LED counter. It debounces three active-low push-buttons (increment, decrement, clear) and arbitrates between them with fixed priority. It then sequences exactly one counter update per accepted press, plus auto-repeat while a button is held. The block sits between the board buttons and `led[3:0]`, and fully owns the counter register.

## Interface
- `DEBOUNCE_COUNT`, default 5000000: consecutive synced cycles a button must differ from its debounced level before that level flips; valid range 1..2^32-1.
- `REPEAT_DELAY`, default 25000000: HOLD count loaded after the first update of a press.
- `REPEAT_RATE`, default 5000000: HOLD count loaded after each repeated update.
- `clk`  in  1  the single clock; all logic on rising edge.
- `rst_btn`  in  1  reset; synchronous and active-low, sampled on `clk` rising edge.
- `inc_btn`  in  1  increment button, active-low, asynchronous to `clk`.
- `dec_btn`  in  1  decrement button, active-low, asynchronous.
- `clr_btn`  in  1  clear button, active-low, asynchronous.
- `led`  out  4  counter value.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `cmd`  out  2  latched command: 0 NONE, 1 INC, 2 DEC, 3 CLR.

## Operation
- Reset (`rst_btn` low at an edge):
  - Outputs: `led`=0, `busy`=0, `cmd`=NONE.
  - FSM goes to IDLE and all counters clear.
  - Sync flops preset to 1 (released); debounced levels go to 0.
  - Reset overrides every state, including mid-repeat.
- Per button, a `btn_debounce` instance does the following:
  - Two-flop synchronizer, then inversion to active-high.
  - A 32-bit counter increments on each edge where the synced value differs from the debounced level, and clears on each edge where they match.
  - The debounced level flips, and the counter clears, on the edge where the count reaches `DEBOUNCE_COUNT`.
- FSM states:
  - IDLE: if any debounced level is high, latch the winner into `cmd` (priority CLR > DEC > INC), clear the `rpt` flag, and go to APPLY.
  - APPLY (one cycle), counter update:
    - INC: `led`+1, 15 wraps to 0.
    - DEC: `led`-1, 0 wraps to 15.
    - CLR: `led`=0.
  - APPLY also loads the hold count: `REPEAT_DELAY` if `rpt`=0, else `REPEAT_RATE`. Then set `rpt`=1 and go to HOLD.
  - HOLD, checked in this priority order:
    - If the latched button's debounced level is low: `cmd`=NONE, go to IDLE.
    - Else if the hold count is 0 and `cmd`≠CLR: go to APPLY.
    - Else decrement the hold count, saturating at 0.
- CLR never repeats; it stays in HOLD until released.
- Buttons other than the latched one are ignored outside IDLE. If another button is still held when the latched one releases, it is arbitrated in IDLE without needing a re-press.
- Simultaneous debounced rises are resolved by priority in the same IDLE cycle.

## Timing
- Latency is counted from the first edge sampling a pin change (edge 0):
  - Synced value available at edge 2.
  - Debounced level flips at edge 2+`DEBOUNCE_COUNT`.
  - APPLY entered at edge 3+`DEBOUNCE_COUNT`.
  - `led` updates at edge 4+`DEBOUNCE_COUNT`.
- Glitches shorter than `DEBOUNCE_COUNT` synced cycles have no effect.
- First repeat update comes `REPEAT_DELAY`+2 edges after the initial update. Subsequent repeat updates are spaced `REPEAT_RATE`+2 edges apart.
- Release: debounced fall at edge e gives IDLE at e+1. If another button is held, its update lands at e+3.
- `busy` and `cmd` are registered and change on the same edge as the state.

## Structure
- Shared package `button_pkg` holds:
  - FSM state encoding: IDLE, APPLY, HOLD.
  - Command encoding: CMD_NONE/INC/DEC/CLR.
  - Counter width constant (32).
- Sub-module `btn_debounce` (params `DEBOUNCE_COUNT`; ports `clk`, `rst_btn`, `btn_n`, `level`) is instantiated three times.
- All counter arithmetic is unsigned. `led` uses 4-bit modulo wrap; counters are 32-bit and never wrap.

## Test plan
All scenarios use `DEBOUNCE_COUNT`=4, `REPEAT_DELAY`=10, `REPEAT_RATE`=3; edges are counted from the first edge sampling the press.
- `inc_btn` low for 3 cycles, then high → `led` stays 0, `busy` stays 0.
- `inc_btn` low for 12 cycles from reset → `led`=1 at edge 8, no further change, `busy` falls after release.
- `inc_btn` held → `led` = 1, 2, 3, 4 at edges 8, 20, 25, 30.
- Wrap at both ends:
  - From 0, press `dec_btn` → `led`=15.
  - From 15, press `inc_btn` → `led`=0.
- From `led`=5, press `clr_btn` and `inc_btn` on the same edge and hold both:
  - `led`=0 at edge 8, `cmd`=3, no repeat.
  - Release `clr_btn` → `led`=1 three edges after its debounced fall.
- Assert `rst_btn` low mid-repeat (`led`=3) → next edge `led`=0, `busy`=0, `cmd`=0. No updates while low. After release, a still-held button is re-debounced from scratch.
